// File: rtl/pulse_t_pkg.sv
// Shared types and defaults for the temporal pulse encoder/decoder stages.
package pulse_t_pkg;

  localparam int unsigned PULSE_T_MAX_VALUE_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pulse_t_state_e;

endpackage

// File: rtl/pulse_t_window_counter.sv
// Window cycle counter: sync clear, load and increment, with a last-cycle flag.
module pulse_t_window_counter
  import pulse_t_pkg::*;
#(
  parameter int unsigned MAX_VALUE = PULSE_T_MAX_VALUE_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(MAX_VALUE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  // Clear has priority so a flush always wins over a window start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(MAX_VALUE - 1));

endmodule

// File: rtl/encoder_pulse_t.sv
// Temporal pulse encoder: one spike per MAX_VALUE-cycle window at the value's cycle.
// Define ENCODER_PULSE_T_STRETCH_EN to hold the line high from spike time to window end.
module encoder_pulse_t
  import pulse_t_pkg::*;
#(
  parameter int unsigned MAX_VALUE = PULSE_T_MAX_VALUE_DEFAULT,
  localparam int unsigned VALUE_W  = $clog2(MAX_VALUE + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VALUE_W-1:0] in_value,
  input  logic               abort,
  output logic               frame_start,
  output logic               outgoing_line,
  output logic               done,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(MAX_VALUE);

  pulse_t_state_e     state_q, state_d;
  logic               pend_valid_q, pend_valid_d;
  logic [VALUE_W-1:0] pend_value_q, pend_value_d;
  logic [VALUE_W-1:0] active_q, active_d;
  logic               cnt_clear, cnt_load, cnt_inc;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_last;
  logic               running;
  logic               line_hit;

  pulse_t_window_counter #(
    .MAX_VALUE (MAX_VALUE),
    .CNT_W     (CNT_W)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .load_value ('0),
    .inc        (cnt_inc),
    .cnt        (cnt),
    .last       (cnt_last)
  );

  // Only path from an input to an output: abort blocks new transfers immediately.
  assign in_ready = !pend_valid_q && !abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_value_q <= '0;
      active_q     <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_value_q <= pend_value_d;
      active_q     <= active_d;
    end
  end

  // Next state, pending buffer and counter control; abort overrides everything.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_value_d = pend_value_q;
    active_d     = active_q;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;

    if (in_valid && in_ready) begin
      pend_valid_d = 1'b1;
      pend_value_d = in_value;
    end

    if (abort) begin
      state_d      = IDLE;
      pend_valid_d = 1'b0;
      cnt_clear    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_valid_q) begin
            state_d      = RUN;
            active_d     = pend_value_q;
            pend_valid_d = 1'b0;
            cnt_load     = 1'b1;
          end
        end
        RUN: begin
          if (cnt_last) begin
            if (pend_valid_q) begin
              active_d     = pend_value_q;
              pend_valid_d = 1'b0;
              cnt_load     = 1'b1;
            end else begin
              state_d   = IDLE;
              cnt_clear = 1'b1;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  // Outputs decode registered state only; active >= MAX_VALUE can never match cnt.
  assign running     = (state_q == RUN);
  assign busy        = running;
  assign frame_start = running && (cnt == '0);
  assign done        = running && cnt_last;

`ifdef ENCODER_PULSE_T_STRETCH_EN
  assign line_hit = (VALUE_W'(cnt) >= active_q);
`else
  assign line_hit = (VALUE_W'(cnt) == active_q);
`endif

  assign outgoing_line = running && line_hit;

endmodule
